reg_bank_irq: RTL and testbench
===============================

Name: reg_bank_irq

Overview:
- Parametrised successor to the single ctrl/status register interface.
- Provides N_CTRL read/write control registers with byte-enable writes and N_STATUS sampled status registers.
- Adds a sticky write-1-to-clear interrupt status register, an interrupt enable register and a read-only ID register.
- Uses a registered read port with valid and error flags, and sits between the bus/host adapter and the datapath blocks.

Parameters:
- ADDR_WIDTH, 8: byte address width.
- DATA_WIDTH, 32: register width; a multiple of 8, at most 32.
- N_CTRL, 4: number of control registers, 1..16.
- N_STATUS, 2: number of status registers, 1..16.
- ID_VALUE, 32'h5247_0001: constant returned by the ID register, truncated to DATA_WIDTH.

Ports:
- clk, in, 1: clock; all logic is on the rising edge.
- reset, in, 1: synchronous, active-high reset.
- addr, in, ADDR_WIDTH: byte address; addr[1:0] is ignored and the register stride is 4.
- wdata, in, DATA_WIDTH: write data.
- wstrb, in, DATA_WIDTH/8: byte enables for the write.
- wen, in, 1: write strobe, one cycle per access.
- ren, in, 1: read strobe, one cycle per access.
- rdata, out, DATA_WIDTH: read data, registered.
- rvalid, out, 1: one-cycle pulse marking valid rdata.
- err, out, 1: one-cycle pulse flagging an invalid access.
- ctrl, out, N_CTRL*DATA_WIDTH: flattened control registers; register i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- status_in, in, N_STATUS*DATA_WIDTH: flattened raw status inputs.
- status, out, N_STATUS*DATA_WIDTH: sampled status registers.
- irq_src, in, DATA_WIDTH: interrupt source levels.
- irq, out, 1: registered interrupt request.

Behaviour:
- Address map (word index = addr>>2):
  - CTRL[i] at 0x00+4i.
  - STATUS[j] at 0x40+4j.
  - IRQ_STAT at 0x80.
  - IRQ_EN at 0x84.
  - ID at 0x88.
  - Anything else is unmapped.
- Reset (reset=1 at a clk edge): the following all become 0.
  - Registers: ctrl, status, IRQ_STAT, IRQ_EN and the irq_src history.
  - Outputs: rdata, rvalid, err, irq.
  - Reset takes priority over every other event, including an access in the same cycle.
- Writes (wen=1 at edge t): the register updates at t; each byte k updates only if wstrb[k]=1.
  - CTRL and IRQ_EN: normal write.
  - IRQ_STAT: each bit with wdata=1 and an enabled byte clears (W1C).
  - STATUS and ID: read-only; the write is ignored and err=1 at t+1.
  - Unmapped address: write is ignored and err=1 at t+1.
- Reads (ren=1 at edge t):
  - rdata and rvalid=1 appear in the cycle after t (latency 1).
  - rdata holds its value until the next read; rvalid and err are single-cycle pulses.
  - Unmapped read: rdata=0, rvalid=1, err=1.
- wen and ren in the same cycle to the same address: the read returns the pre-write value and the write still takes effect. err is the OR of both checks.
- status: status register j captures status_in slice j every cycle (one-cycle delay). A read of STATUS returns the registered value.
- IRQ_STAT:
  - Bit b sets on a rising edge of irq_src[b] (current=1, previous cycle=0). irq_src is assumed to be synchronous to clk.
  - The bit stays set until cleared by W1C.
  - If a set and a W1C clear happen in the same cycle, the set wins.
  - A level held high does not re-set the bit after it is cleared.
- irq = |(IRQ_STAT & IRQ_EN), registered; it lags the state change by one cycle.
- No back-pressure: one access per cycle is accepted unconditionally.

Decomposition:
- Package reg_bank_pkg holds:
  - Address offset constants: CTRL_BASE=0x00, STATUS_BASE=0x40, IRQ_STAT_ADDR=0x80, IRQ_EN_ADDR=0x84, ID_ADDR=0x88.
  - The ID default value.
  - The address-decode result enum: DEC_CTRL, DEC_STATUS, DEC_IRQ_STAT, DEC_IRQ_EN, DEC_ID, DEC_NONE.
- Sub-module irq_ctrl contains the edge detect, sticky W1C IRQ_STAT, IRQ_EN and registered irq output.
- The top level contains the decode, CTRL/STATUS storage and read mux.

Test Plan:
1. Reset, then write CTRL[2] (0x08) with 0xDEADBEEF and wstrb=4'b0101, then read 0x08 → rdata=0x00AD00EF with one rvalid pulse one cycle after ren; ctrl slice 2 = 0x00AD00EF; the other slices = 0.
2. Set status_in slice 1 = 0xA5A5A5A5 and wait 1 cycle, then read 0x44 → rdata=0xA5A5A5A5 and status slice 1 matches. Write 0x44 → err pulse, and a re-read returns the value unchanged.
3. Set IRQ_EN=0x1 and pulse irq_src[0] 0→1 → IRQ_STAT=0x1 and irq=1 one cycle later. Keep irq_src[0]=1 and write 0x80 with 0x1 → IRQ_STAT=0 and irq drops; the bit does not re-set.
4. W1C of bit 3 in the same cycle as a rising edge on irq_src[3] → IRQ_STAT[3] stays 1. With IRQ_EN=0, irq stays 0.
5. Read 0x88 → 0x52470001. Read 0xF0 → rdata=0 with rvalid=1 and err=1.
6. Write 0xFFFFFFFF to CTRL[0] with a simultaneous read of 0x00 → the read returns 0 and the next read returns 0xFFFFFFFF. Asserting reset together with wen → all registers and outputs are 0 the next cycle.

Source files
------------

// File: rtl/reg_bank_pkg.sv
// Shared constants, decode types and the address decoder for reg_bank_irq.
package reg_bank_pkg;

  localparam logic [31:0] CTRL_BASE     = 32'h0000_0000;
  localparam logic [31:0] STATUS_BASE   = 32'h0000_0040;
  localparam logic [31:0] IRQ_STAT_ADDR = 32'h0000_0080;
  localparam logic [31:0] IRQ_EN_ADDR   = 32'h0000_0084;
  localparam logic [31:0] ID_ADDR       = 32'h0000_0088;

  localparam logic [31:0] ID_DEFAULT    = 32'h5247_0001;

  localparam int unsigned IDX_WIDTH     = 4;

  typedef enum logic [2:0] {
    DEC_CTRL,
    DEC_STATUS,
    DEC_IRQ_STAT,
    DEC_IRQ_EN,
    DEC_ID,
    DEC_NONE
  } dec_e;

  typedef struct packed {
    dec_e                 kind;
    logic [IDX_WIDTH-1:0] idx;
  } dec_t;

  // Map a byte address to a register class and index; addr[1:0] is ignored.
  function automatic dec_t decode(logic [31:0] addr, int unsigned n_ctrl,
                                  int unsigned n_status);
    dec_t        d;
    logic [31:0] word_addr;
    logic [31:0] ctrl_off;
    logic [31:0] stat_off;
    word_addr = {addr[31:2], 2'b00};
    ctrl_off  = word_addr - CTRL_BASE;
    stat_off  = word_addr - STATUS_BASE;
    d.kind    = DEC_NONE;
    d.idx     = '0;
    // Offsets wrap for addresses below the base, so one unsigned compare suffices.
    if (ctrl_off < (32'(n_ctrl) << 2)) begin
      d.kind = DEC_CTRL;
      d.idx  = ctrl_off[IDX_WIDTH+1:2];
    end else if (stat_off < (32'(n_status) << 2)) begin
      d.kind = DEC_STATUS;
      d.idx  = stat_off[IDX_WIDTH+1:2];
    end else if (word_addr == IRQ_STAT_ADDR) begin
      d.kind = DEC_IRQ_STAT;
    end else if (word_addr == IRQ_EN_ADDR) begin
      d.kind = DEC_IRQ_EN;
    end else if (word_addr == ID_ADDR) begin
      d.kind = DEC_ID;
    end
    return d;
  endfunction

endpackage

// File: rtl/reg_bank_irq_if.sv
// Register-bus interface between the host adapter (master) and reg_bank_irq (slave).
// addr/wdata/wstrb/wen/ren flow master->slave; rdata/rvalid/err flow back.
interface reg_bank_irq_if #(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32
);
  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;
  logic [STRB_WIDTH-1:0] wstrb;
  logic                  wen;
  logic                  ren;
  logic [DATA_WIDTH-1:0] rdata;
  logic                  rvalid;
  logic                  err;

  modport master (
    output addr, wdata, wstrb, wen, ren,
    input  rdata, rvalid, err
  );

  modport slave (
    input  addr, wdata, wstrb, wen, ren,
    output rdata, rvalid, err
  );
endinterface

// File: rtl/reg_bank_irq_irq_ctrl.sv
// Interrupt block: rising-edge detect on irq_src, sticky W1C status,
// enable register and registered irq request.
// Ports: clk, reset (sync, active-high), irq_src levels, wdata/wmask write
// payload, stat_we (W1C strobe), en_we (enable write strobe),
// irq_stat/irq_en register values, irq output.
module irq_ctrl #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] irq_src,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [DATA_WIDTH-1:0] wmask,
  input  logic                  stat_we,
  input  logic                  en_we,
  output logic [DATA_WIDTH-1:0] irq_stat,
  output logic [DATA_WIDTH-1:0] irq_en,
  output logic                  irq
);

  logic [DATA_WIDTH-1:0] src_q;
  logic [DATA_WIDTH-1:0] rise_c;
  logic [DATA_WIDTH-1:0] clr_c;

  // Edge and clear masks; a set in the same cycle as a clear wins.
  always_comb begin
    rise_c = irq_src & ~src_q;
    clr_c  = '0;
    if (stat_we) clr_c = wdata & wmask;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      src_q    <= '0;
      irq_stat <= '0;
      irq_en   <= '0;
      irq      <= 1'b0;
    end else begin
      src_q    <= irq_src;
      irq_stat <= (irq_stat & ~clr_c) | rise_c;
      if (en_we) irq_en <= (irq_en & ~wmask) | (wdata & wmask);
      irq      <= |(irq_stat & irq_en);
    end
  end

endmodule

// File: rtl/reg_bank_irq.sv
// Parametrised control/status register bank with interrupt support.
// Ports: clk, reset (sync, active-high), bus (register access slave port:
// addr/wdata/wstrb/wen/ren in, registered rdata/rvalid/err out),
// ctrl (flattened control registers), status_in (raw status),
// status (sampled status), irq_src (interrupt levels), irq (request).
module reg_bank_irq
  import reg_bank_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 8,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned N_CTRL     = 4,
  parameter int unsigned N_STATUS   = 2,
  parameter logic [31:0] ID_VALUE   = ID_DEFAULT
) (
  input  logic                           clk,
  input  logic                           reset,
  reg_bank_irq_if.slave                  bus,
  output logic [N_CTRL*DATA_WIDTH-1:0]   ctrl,
  input  logic [N_STATUS*DATA_WIDTH-1:0] status_in,
  output logic [N_STATUS*DATA_WIDTH-1:0] status,
  input  logic [DATA_WIDTH-1:0]          irq_src,
  output logic                           irq
);

  localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

  logic [ADDR_WIDTH-1:0] addr_c;
  logic [STRB_WIDTH-1:0] wstrb_c;
  dec_t                  dec_c;
  logic [DATA_WIDTH-1:0] wmask_c;
  logic [DATA_WIDTH-1:0] rd_c;
  logic                  err_c;
  logic [DATA_WIDTH-1:0] irq_stat;
  logic [DATA_WIDTH-1:0] irq_en;

  assign addr_c  = bus.addr;
  assign wstrb_c = bus.wstrb;
  assign dec_c   = decode(32'(addr_c), N_CTRL, N_STATUS);

  // Expand byte enables to a bit mask.
  always_comb begin
    wmask_c = '0;
    for (int k = 0; k < int'(STRB_WIDTH); k++) wmask_c[k*8 +: 8] = {8{wstrb_c[k]}};
  end

  // Control register writes.
  always_ff @(posedge clk) begin
    if (reset) begin
      ctrl <= '0;
    end else if (bus.wen && dec_c.kind == DEC_CTRL) begin
      for (int i = 0; i < int'(N_CTRL); i++) begin
        if (dec_c.idx == IDX_WIDTH'(i))
          ctrl[i*DATA_WIDTH +: DATA_WIDTH] <= (ctrl[i*DATA_WIDTH +: DATA_WIDTH] & ~wmask_c)
                                            | (bus.wdata & wmask_c);
      end
    end
  end

  // Status sampling, one cycle behind status_in.
  always_ff @(posedge clk) begin
    if (reset) status <= '0;
    else       status <= status_in;
  end

  irq_ctrl #(.DATA_WIDTH(DATA_WIDTH)) u_irq_ctrl (
    .clk      (clk),
    .reset    (reset),
    .irq_src  (irq_src),
    .wdata    (bus.wdata),
    .wmask    (wmask_c),
    .stat_we  (bus.wen && dec_c.kind == DEC_IRQ_STAT),
    .en_we    (bus.wen && dec_c.kind == DEC_IRQ_EN),
    .irq_stat (irq_stat),
    .irq_en   (irq_en),
    .irq      (irq)
  );

  // Read mux over pre-write register values; unmapped reads return zero.
  always_comb begin
    rd_c = '0;
    case (dec_c.kind)
      DEC_CTRL: begin
        for (int i = 0; i < int'(N_CTRL); i++)
          if (dec_c.idx == IDX_WIDTH'(i)) rd_c = ctrl[i*DATA_WIDTH +: DATA_WIDTH];
      end
      DEC_STATUS: begin
        for (int j = 0; j < int'(N_STATUS); j++)
          if (dec_c.idx == IDX_WIDTH'(j)) rd_c = status[j*DATA_WIDTH +: DATA_WIDTH];
      end
      DEC_IRQ_STAT: rd_c = irq_stat;
      DEC_IRQ_EN:   rd_c = irq_en;
      DEC_ID:       rd_c = ID_VALUE[DATA_WIDTH-1:0];
      default:      rd_c = '0;
    endcase
  end

  // Writes to read-only or unmapped locations and unmapped reads are errors.
  always_comb begin
    err_c = (bus.ren && dec_c.kind == DEC_NONE)
         || (bus.wen && (dec_c.kind == DEC_NONE || dec_c.kind == DEC_STATUS
                         || dec_c.kind == DEC_ID));
  end

  // Registered read response; rdata holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      bus.rdata  <= '0;
      bus.rvalid <= 1'b0;
      bus.err    <= 1'b0;
    end else begin
      bus.rvalid <= bus.ren;
      bus.err    <= err_c;
      if (bus.ren) bus.rdata <= rd_c;
    end
  end

endmodule

// File: tb/tb_reg_bank_irq.sv
// Self-checking bench for reg_bank_irq: bus responses are scored against a
// queue of expectations pushed when each access is driven.
module tb_reg_bank_irq;
  import reg_bank_pkg::*;

  logic         clk = 1'b0;
  logic         reset;
  logic [127:0] ctrl;
  logic [63:0]  status_in;
  logic [63:0]  status;
  logic [31:0]  irq_src;
  logic         irq;

  int unsigned  n_checks = 0;
  int unsigned  n_fails  = 0;
  int unsigned  cyc      = 0;
  bit           mon_en   = 1'b0;

  typedef struct {
    bit          rd;
    logic [31:0] data;
    bit          err;
    int unsigned due;
    string       tag;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;

  reg_bank_irq_if #(.ADDR_WIDTH(8), .DATA_WIDTH(32)) bus ();

  reg_bank_irq #(
    .ADDR_WIDTH (8),
    .DATA_WIDTH (32),
    .N_CTRL     (4),
    .N_STATUS   (2),
    .ID_VALUE   (32'h5247_0001)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .ctrl      (ctrl),
    .status_in (status_in),
    .status    (status),
    .irq_src   (irq_src),
    .irq       (irq)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %08h expected %08h (t=%0t)", tag, act, exp, $time);
    end
  endtask

  // Drive one access for a single cycle and record the expected response.
  task automatic bus_op(input bit w, input bit r, input logic [7:0] a,
                        input logic [31:0] d, input logic [3:0] s,
                        input logic [31:0] exp_d, input bit exp_e, input string tag);
    exp_t e;
    bus.addr  = a;
    bus.wdata = d;
    bus.wstrb = s;
    bus.wen   = w;
    bus.ren   = r;
    e.rd = r; e.data = exp_d; e.err = exp_e; e.due = cyc + 1; e.tag = tag;
    sb_q.push_back(e);
    @(posedge clk); #1;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Response monitor: score due entries, otherwise expect a quiet bus.
  always @(negedge clk) begin
    if (mon_en) begin
      if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
        mon_e = sb_q.pop_front();
        check_eq({mon_e.tag, "_rvalid"}, 32'(bus.rvalid), 32'(mon_e.rd));
        check_eq({mon_e.tag, "_err"}, 32'(bus.err), 32'(mon_e.err));
        if (mon_e.rd) check_eq({mon_e.tag, "_rdata"}, bus.rdata, mon_e.data);
      end else begin
        check_eq("idle_rvalid", 32'(bus.rvalid), 32'd0);
        check_eq("idle_err", 32'(bus.err), 32'd0);
      end
    end
  end

  initial begin
    reset     = 1'b1;
    bus.addr  = '0;
    bus.wdata = '0;
    bus.wstrb = '0;
    bus.wen   = 1'b0;
    bus.ren   = 1'b0;
    status_in = '0;
    irq_src   = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    check_eq("rst_rdata", bus.rdata, 32'd0);
    check_eq("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("rst_err", 32'(bus.err), 32'd0);
    check_eq("rst_irq", 32'(irq), 32'd0);
    check_eq("rst_ctrl0", ctrl[31:0], 32'd0);
    check_eq("rst_status0", status[31:0], 32'd0);
    mon_en = 1'b1;

    // 1: byte-enabled control write
    bus_op(1, 0, 8'h08, 32'hDEAD_BEEF, 4'b0101, 32'h0, 0, "wr_ctrl2");
    bus_op(0, 1, 8'h08, 32'h0, 4'h0, 32'h00AD_00EF, 0, "rd_ctrl2");
    check_eq("ctrl_slice2", ctrl[95:64], 32'h00AD_00EF);
    check_eq("ctrl_slice0", ctrl[31:0], 32'h0);
    check_eq("ctrl_slice1", ctrl[63:32], 32'h0);
    check_eq("ctrl_slice3", ctrl[127:96], 32'h0);
    bus_op(0, 1, 8'h0C, 32'h0, 4'h0, 32'h0, 0, "rd_ctrl3");

    // 2: status sampling and read-only protection
    status_in[63:32] = 32'hA5A5_A5A5;
    idle(1);
    bus_op(0, 1, 8'h44, 32'h0, 4'h0, 32'hA5A5_A5A5, 0, "rd_stat1");
    check_eq("status_slice1", status[63:32], 32'hA5A5_A5A5);
    bus_op(1, 0, 8'h44, 32'h1234_5678, 4'hF, 32'h0, 1, "wr_stat1");
    bus_op(0, 1, 8'h44, 32'h0, 4'h0, 32'hA5A5_A5A5, 0, "rerd_stat1");

    // 3: edge-triggered interrupt, W1C with level still high
    bus_op(1, 0, 8'h84, 32'h1, 4'hF, 32'h0, 0, "wr_en1");
    irq_src[0] = 1'b1;
    idle(1);
    check_eq("irq_lag", 32'(irq), 32'd0);
    idle(1);
    check_eq("irq_set", 32'(irq), 32'd1);
    bus_op(0, 1, 8'h80, 32'h0, 4'h0, 32'h1, 0, "rd_istat_set");
    bus_op(1, 0, 8'h80, 32'h1, 4'hF, 32'h0, 0, "w1c_b0");
    check_eq("irq_hold", 32'(irq), 32'd1);
    bus_op(0, 1, 8'h80, 32'h0, 4'h0, 32'h0, 0, "rd_istat_clr");
    check_eq("irq_drop", 32'(irq), 32'd0);
    idle(2);
    bus_op(0, 1, 8'h80, 32'h0, 4'h0, 32'h0, 0, "rd_istat_noreset");

    // 4: set beats simultaneous clear; disabled source keeps irq low
    bus_op(1, 0, 8'h84, 32'h0, 4'hF, 32'h0, 0, "wr_en0");
    irq_src[3] = 1'b1;
    idle(1);
    irq_src[3] = 1'b0;
    idle(1);
    irq_src[3] = 1'b1;
    bus_op(1, 0, 8'h80, 32'h8, 4'hF, 32'h0, 0, "w1c_b3_race");
    bus_op(0, 1, 8'h80, 32'h0, 4'h0, 32'h8, 0, "rd_istat_race");
    bus_op(0, 1, 8'h84, 32'h0, 4'h0, 32'h0, 0, "rd_en");
    idle(2);
    check_eq("irq_disabled", 32'(irq), 32'd0);

    // 5: ID and unmapped accesses
    bus_op(0, 1, 8'h88, 32'h0, 4'h0, 32'h5247_0001, 0, "rd_id");
    bus_op(0, 1, 8'hF0, 32'h0, 4'h0, 32'h0, 1, "rd_unmapped");
    bus_op(0, 1, 8'h48, 32'h0, 4'h0, 32'h0, 1, "rd_stat2_oob");
    bus_op(0, 1, 8'h10, 32'h0, 4'h0, 32'h0, 1, "rd_ctrl4_oob");
    bus_op(1, 0, 8'h88, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, "wr_id");
    bus_op(1, 0, 8'hF0, 32'hFFFF_FFFF, 4'hF, 32'h0, 1, "wr_unmapped");
    bus_op(1, 1, 8'hF4, 32'h1, 4'hF, 32'h0, 1, "rw_unmapped");

    // 6: read-during-write, then reset colliding with an access
    bus_op(1, 1, 8'h00, 32'hFFFF_FFFF, 4'hF, 32'h0, 0, "rw_ctrl0");
    bus_op(0, 1, 8'h00, 32'h0, 4'h0, 32'hFFFF_FFFF, 0, "rd_ctrl0");
    irq_src = '0;
    bus_op(1, 0, 8'h84, 32'hF, 4'hF, 32'h0, 0, "wr_en_f");
    check_eq("irq_pre_rst", 32'(irq), 32'd0);
    bus_op(0, 1, 8'h80, 32'h0, 4'h0, 32'h8, 0, "rd_istat_pre");
    check_eq("irq_pre_rst2", 32'(irq), 32'd1);
    reset     = 1'b1;
    bus.addr  = 8'h04;
    bus.wdata = 32'h1234_5678;
    bus.wstrb = 4'hF;
    bus.wen   = 1'b1;
    bus.ren   = 1'b1;
    @(posedge clk); #1;
    reset   = 1'b0;
    bus.wen = 1'b0;
    bus.ren = 1'b0;
    check_eq("rst2_ctrl0", ctrl[31:0], 32'h0);
    check_eq("rst2_ctrl1", ctrl[63:32], 32'h0);
    check_eq("rst2_ctrl2", ctrl[95:64], 32'h0);
    check_eq("rst2_status1", status[63:32], 32'h0);
    check_eq("rst2_rdata", bus.rdata, 32'h0);
    check_eq("rst2_rvalid", 32'(bus.rvalid), 32'd0);
    check_eq("rst2_err", 32'(bus.err), 32'd0);
    check_eq("rst2_irq", 32'(irq), 32'd0);
    bus_op(0, 1, 8'h80, 32'h0, 4'h0, 32'h0, 0, "rd_istat_post");
    bus_op(0, 1, 8'h84, 32'h0, 4'h0, 32'h0, 0, "rd_en_post");
    bus_op(0, 1, 8'h04, 32'h0, 4'h0, 32'h0, 0, "rd_ctrl1_post");

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 8 && sb_q.size() > 0; i++) @(posedge clk);
    idle(1);
    check_eq("sb_drain", 32'(sb_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
